btn_event_tx: RTL and testbench
===============================

Name: btn_event_tx

Overview:
- Downstream consumer of the push-button debouncers. Each debouncer output is a single-cycle `src_clk` pulse, one pulse per button release.
- The block latches pulses from up to 8 buttons and encodes each into an event byte.
- Event bytes are buffered in a small first-word-fall-through (FWFT) FIFO and handed to the UART transmitter over a valid/ready handshake.
- Lets the board report button activity over the serial link without losing closely spaced presses.

Parameters:
- NUM_BTN, 4, number of debounced button inputs; legal range 1..8.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- src_clk, input, 1, system clock; sole clock domain.
- rst, input, 1, synchronous active-high reset.
- btn_pulse, input, NUM_BTN, one-cycle debounced release pulses; bit i = button i.
- tx_ready, input, 1, UART TX can accept a byte this cycle.
- tx_valid, output, 1, tx_data holds a valid event byte.
- tx_data, output, 8, event byte at the FIFO head.
- fifo_count, output, FIFO_AW+1, current FIFO occupancy, 0..2**FIFO_AW.
- overflow, output, 1, sticky flag: an event was dropped.
- clr_overflow, input, 1, clears overflow.

Behaviour:
- Clock and reset: one clock, `src_clk`. Reset is synchronous and active-high on `rst`, sampled at the `src_clk` rising edge.
- Reset values: pend=0, seq=0, FIFO empty, tx_valid=0, tx_data=0, fifo_count=0, overflow=0.
- Stage 1, pending latch:
  - pend[NUM_BTN-1:0] captures pulses: at each edge, pend <= (pend & ~grant) | btn_pulse.
  - A pulse on the same cycle its bit is granted re-arms the bit, so the new press is kept.
- Stage 2, encoder:
  - Each cycle, if pend != 0 and the FIFO can accept, grant = the lowest-index set pend bit (one-hot).
  - The granted button's event byte is pushed at that edge.
  - "Can accept" means fifo_count < depth, or a pop occurs in the same cycle.
- Event byte: {seq[4:0], id[2:0]}.
  - id = granted button index.
  - seq increments by 1 on every push and wraps 31 -> 0.
- Latency: pulse sampled at edge k -> pushed at edge k+1 -> tx_valid=1 after edge k+1. This assumes the FIFO is empty and no lower-index pend bit is set.
- Simultaneous pulses are serviced lowest index first, one per cycle, with consecutive seq values.
- Drop and overflow rule:
  - If btn_pulse[i]=1 while pend[i]=1 and bit i is not granted that cycle, the new pulse is coalesced (lost).
  - In that case overflow is set to 1 at that edge.
  - While the FIFO is full, pending bits are held, not dropped.
- overflow persistence:
  - overflow stays 1 until clr_overflow=1.
  - If clr_overflow and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- FIFO output:
  - FWFT: tx_valid = (fifo_count != 0) and tx_data = head entry, both registered/derived from the FIFO state.
  - Pop on tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable.
  - tx_ready while empty is ignored.
- Push and pop in the same cycle: count is unchanged and is legal when full. The pointers wrap modulo depth.
- Reset mid-operation: all pending and buffered events are discarded; no partial byte is presented after reset.

Optional Feature:
- Macro: BTN_EVT_ASCII_EN.
- When defined, tx_data = 8'h41 + id (ASCII 'A'..'H'), for human-readable terminal output. The seq counter is still maintained internally but is not emitted.
- When not defined, the packed {seq, id} format above is used.
- FIFO width, handshake and timing are identical in both builds.

Test Plan:
- Single press: rst released, tx_ready=1, pulse btn_pulse=4'b0100 for one cycle -> tx_valid high 2 cycles after the pulse with tx_data=8'h02 (seq 0, id 2) for one cycle; fifo_count returns to 0.
- Simultaneous press: tx_ready=0, pulse 4'b1011 in one cycle -> FIFO contents in order 8'h00, 8'h09, 8'h13; fifo_count=3; overflow=0.
- Backpressure and full: tx_ready=0, issue 10 spaced pulses on btn 0 -> fifo_count saturates at 8 and pend[0] holds the 9th press. The 10th press sets overflow=1. Then tx_ready=1 -> 9 bytes drain with seq 0..8, and tx_data is stable during every stall.
- Seq wrap: 33 accepted events on btn 1 -> the 33rd byte (index 32) is 8'h01 (seq wrapped to 0).
- Re-arm on grant: pulse btn 3 at cycle k and again at k+1 (grant cycle) -> two events, overflow stays 0. Then assert clr_overflow after any forced overflow -> overflow=0 next cycle.
- Reset mid-stream: 5 bytes queued, rst pulsed one cycle -> tx_valid=0, fifo_count=0, and the next event carries seq 0. With BTN_EVT_ASCII_EN, a btn 2 press yields tx_data=8'h43.

Source files
------------

// File: rtl/btn_event_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_event_tx: latches debounced button pulses, encodes them as event     |
// | bytes and queues them in a FWFT FIFO for a valid/ready UART transmitter. |
// | Optional build macro BTN_EVT_ASCII_EN selects ASCII 'A'+id output.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module btn_event_tx #(
    parameter int NUM_BTN = 4,
    parameter int FIFO_AW = 3
) (
    input  logic               src_clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);

    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [4:0]         seq_q, seq_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic               pop;
    logic               push;
    logic               can_accept;
    logic               drop;
    logic [NUM_BTN-1:0] grant;
    logic [2:0]         grant_id;
    logic [7:0]         evt_byte;

    // Arbitration: lowest-index pending button wins whenever the FIFO has room
    // now, or will have room because the head is leaving this same cycle.
    always_comb begin
        pop        = (count_q != '0) && tx_ready;
        can_accept = (count_q < DEPTH_CNT) || pop;
        grant      = '0;
        grant_id   = '0;
        if (can_accept) begin
            for (int i = NUM_BTN - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    grant_id = 3'(i);
                end
            end
        end
        push = |grant;
        drop = |(btn_pulse & pend_q & ~grant);
    end

    always_comb begin
`ifdef BTN_EVT_ASCII_EN
        evt_byte = 8'h41 + {5'd0, grant_id};
`else
        evt_byte = {seq_q, grant_id};
`endif
    end

    always_comb begin
        pend_d   = (pend_q & ~grant) | btn_pulse;
        seq_d    = push ? seq_q + 5'd1 : seq_q;
        ovf_d    = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = evt_byte;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            pend_q   <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            pend_q   <= pend_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is gated so an empty FIFO never shows stale bytes.
    assign tx_valid   = (count_q != '0);
    assign tx_data    = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btn_event_tx: directed and randomized bench for btn_event_tx against  |
// | a queue-based event model. Honors BTN_EVT_ASCII_EN when defined.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_btn_event_tx;

    localparam int NUM_BTN = 4;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;

`ifdef BTN_EVT_ASCII_EN
    localparam logic [7:0] L_SINGLE = 8'h43, L_S0 = 8'h41, L_S1 = 8'h42, L_S2 = 8'h44;
    localparam logic [7:0] L_WRAP   = 8'h42, L_RST = 8'h43;
`else
    localparam logic [7:0] L_SINGLE = 8'h02, L_S0 = 8'h00, L_S1 = 8'h09, L_S2 = 8'h13;
    localparam logic [7:0] L_WRAP   = 8'h01, L_RST = 8'h02;
`endif

    logic               src_clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               tx_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;
    logic               clr_overflow;

    always #5 src_clk = ~src_clk;

    btn_event_tx #(.NUM_BTN(NUM_BTN), .FIFO_AW(FIFO_AW)) dut (
        .src_clk      (src_clk),
        .rst          (rst),
        .btn_pulse    (btn_pulse),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending flags, a byte queue and a sequence number.
    logic [7:0] m_q [$];
    logic [7:0] popped [$];
    bit         m_pend [NUM_BTN];
    int         m_seq   = 0;
    bit         m_ovf   = 1'b0;
    bit         m_stall = 1'b0;
    logic [7:0] last_data = 8'h00;

    function automatic logic [7:0] evt(input int seq, input int id);
`ifdef BTN_EVT_ASCII_EN
        return 8'h41 + 8'(id);
`else
        return {5'(seq), 3'(id)};
`endif
    endfunction

    always @(posedge src_clk) begin
        int g;
        bit pop, acc, drop;
        if (rst) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_seq   = 0;
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else begin
            pop     = (m_q.size() != 0) && tx_ready;
            m_stall = (m_q.size() != 0) && !tx_ready;
            if (pop) popped.push_back(last_data);
            acc = (m_q.size() < DEPTH) || pop;
            g   = -1;
            if (acc)
                for (int i = 0; i < NUM_BTN; i++)
                    if (m_pend[i] && g < 0) g = i;
            drop = 1'b0;
            for (int i = 0; i < NUM_BTN; i++)
                if (btn_pulse[i] && m_pend[i] && i != g) drop = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(evt(m_seq, g));
                m_seq     = (m_seq + 1) % 32;
                m_pend[g] = 1'b0;
            end
            for (int i = 0; i < NUM_BTN; i++)
                if (btn_pulse[i]) m_pend[i] = 1'b1;
            if (drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    always @(negedge src_clk) begin
        if (chk_en) begin
            check("tx_valid", tx_valid, m_q.size() != 0);
            check("fifo_count", fifo_count, m_q.size());
            check("overflow", overflow, m_ovf);
            if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
            if (m_stall) check("stall_hold", tx_data, last_data);
        end
        last_data = tx_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge src_clk);
            @(negedge src_clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_pulse = '0;
        clr_overflow = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        rst = 1'b1; tx_ready = 1'b0; clr_overflow = 1'b0; btn_pulse = '0;
        tick(2);
        chk_en = 1'b1;
        check("rst_valid", tx_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // single press
        tx_ready = 1'b1; btn_pulse = 4'b0100; tick();
        btn_pulse = '0; tick();
        check("single_valid", tx_valid, 1'b1);
        check("single_data", tx_data, L_SINGLE);
        tick();
        check("single_drain", fifo_count, 0);

        // simultaneous press
        do_reset(); tx_ready = 1'b0; btn_pulse = 4'b1011; tick();
        btn_pulse = '0; tick(3);
        check("simul_count", fifo_count, 3);
        check("simul_head0", tx_data, L_S0);
        check("simul_ovf", overflow, 1'b0);
        tx_ready = 1'b1; tick();
        check("simul_head1", tx_data, L_S1);
        tick();
        check("simul_head2", tx_data, L_S2);
        tick();
        check("simul_empty", fifo_count, 0);

        // backpressure, full, overflow
        do_reset(); tx_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            btn_pulse = 4'b0001; tick();
            btn_pulse = '0; tick();
        end
        check("full_count", fifo_count, 8);
        check("full_ovf", overflow, 1'b1);
        tx_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
`ifdef BTN_EVT_ASCII_EN
            check("drain_byte", tx_data, 8'h41);
`else
            check("drain_byte", tx_data, 8'(j * 8));
`endif
            tick();
        end
        check("drain_empty", fifo_count, 0);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        check("clr_ovf", overflow, 1'b0);

        // sequence wrap
        do_reset(); tx_ready = 1'b1; popped.delete();
        for (int n = 0; n < 33; n++) begin
            btn_pulse = 4'b0010; tick();
            btn_pulse = '0; tick($urandom_range(1, 3));
        end
        tick(3);
        check("wrap_count", popped.size(), 33);
        if (popped.size() > 32) check("wrap_byte", popped[32], L_WRAP);
        else check("wrap_byte_missing", popped.size(), 33);

        // re-arm on grant, forced overflow, clear vs drop priority
        do_reset(); tx_ready = 1'b1; n0 = popped.size();
        btn_pulse = 4'b1000; tick(); tick();
        btn_pulse = '0; tick(3);
        check("rearm_ovf", overflow, 1'b0);
        check("rearm_events", popped.size() - n0, 2);
        btn_pulse = 4'b1001; tick();
        btn_pulse = 4'b1000; tick();
        btn_pulse = '0;
        check("forced_ovf", overflow, 1'b1);
        tick(3);
        btn_pulse = 4'b1001; tick();
        btn_pulse = 4'b1000; clr_overflow = 1'b1; tick();
        check("drop_beats_clr", overflow, 1'b1);
        btn_pulse = '0; tick();
        clr_overflow = 1'b0;
        check("clr_after", overflow, 1'b0);
        tick(3);

        // reset mid-stream
        do_reset(); tx_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            btn_pulse = 4'b0001; tick();
            btn_pulse = '0; tick();
        end
        check("mid_count", fifo_count, 5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_valid", tx_valid, 1'b0);
        check("mid_zero", fifo_count, 0);
        btn_pulse = 4'b0100; tick();
        btn_pulse = '0; tick();
        check("mid_valid2", tx_valid, 1'b1);
        check("mid_data", tx_data, L_RST);

        // randomized traffic in phases of varying backpressure
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            int ready_pct;
            ready_pct = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 500; c++) begin
                for (int b = 0; b < NUM_BTN; b++)
                    btn_pulse[b] = ($urandom_range(0, 99) < 15);
                tx_ready     = ($urandom_range(0, 99) < ready_pct);
                clr_overflow = ($urandom_range(0, 19) == 0);
                rst          = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0; btn_pulse = '0; clr_overflow = 1'b0; tx_ready = 1'b1;
        tick(12);
        check("final_empty", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
